// File: rtl/simmem_release_scheduler.sv
// Per-ID release scheduler: holds request descriptors in slots, counts each delay down and
// enables an ID once its oldest request matures. Optional error flag: SIMMEM_RELEASE_SCHED_ERR_EN.
module simmem_release_scheduler #(
  parameter int unsigned IDWidth    = 4,
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [IDWidth-1:0]          req_id_i,
  input  logic [DelayWidth-1:0]       req_delay_i,
  input  logic                        rsp_done_i,
  input  logic [IDWidth-1:0]          rsp_id_i,
  output logic [2**IDWidth-1:0]       release_en_o,
  output logic [$clog2(NumSlots):0]   outstanding_o,
  output logic                        err_o
);

  localparam int unsigned SlotW = $clog2(NumSlots);

  localparam logic [DelayWidth-1:0] CntOne  = DelayWidth'(1);
  localparam logic [SlotW-1:0]      RankOne = SlotW'(1);
  localparam logic [SlotW:0]        OccOne  = (SlotW + 1)'(1);

  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [IDWidth-1:0]    id_q   [NumSlots];
  logic [IDWidth-1:0]    id_d   [NumSlots];
  logic [DelayWidth-1:0] cnt_q  [NumSlots];
  logic [DelayWidth-1:0] cnt_d  [NumSlots];
  logic [SlotW-1:0]      rank_q [NumSlots];
  logic [SlotW-1:0]      rank_d [NumSlots];

  logic                  ready;
  logic                  accept;
  logic [SlotW-1:0]      alloc_idx;
  logic [NumSlots-1:0]   matured;
  logic [NumSlots-1:0]   retire_hit;
  logic                  hit;
  logic [SlotW-1:0]      same_cnt;
  logic [SlotW-1:0]      rank_new;
  logic [SlotW:0]        occ;

  // Slot search, maturity and same-ID bookkeeping, all from registered state.
  always_comb begin
    ready      = 1'b0;
    alloc_idx  = '0;
    matured    = '0;
    retire_hit = '0;
    same_cnt   = '0;
    occ        = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (!valid_q[i]) begin
        if (!ready) begin
          alloc_idx = SlotW'(i);
        end
        ready = 1'b1;
      end else begin
        occ = occ + OccOne;
      end
      matured[i]    = valid_q[i] && (rank_q[i] == '0) && (cnt_q[i] == '0);
      retire_hit[i] = rsp_done_i && matured[i] && (id_q[i] == rsp_id_i);
      if (valid_q[i] && (id_q[i] == req_id_i)) begin
        same_cnt = same_cnt + RankOne;
      end
    end
    hit    = |retire_hit;
    accept = req_valid_i && ready;
    // A same-cycle retire of this ID removes one older slot from the count.
    rank_new = (hit && (rsp_id_i == req_id_i)) ? (same_cnt - RankOne) : same_cnt;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumSlots; i++) begin
      valid_d[i] = valid_q[i];
      id_d[i]    = id_q[i];
      cnt_d[i]   = cnt_q[i];
      rank_d[i]  = rank_q[i];
      if (valid_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      if (retire_hit[i]) begin
        valid_d[i] = 1'b0;
      end else if (hit && valid_q[i] && (id_q[i] == rsp_id_i)) begin
        rank_d[i] = rank_q[i] - RankOne;
      end
      if (accept && (alloc_idx == SlotW'(i))) begin
        valid_d[i] = 1'b1;
        id_d[i]    = req_id_i;
        cnt_d[i]   = req_delay_i;
        rank_d[i]  = rank_new;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NumSlots; i++) begin
        id_q[i]   <= '0;
        cnt_q[i]  <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < NumSlots; i++) begin
        id_q[i]   <= id_d[i];
        cnt_q[i]  <= cnt_d[i];
        rank_q[i] <= rank_d[i];
      end
    end
  end

  always_comb begin
    release_en_o = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (matured[i]) begin
        release_en_o[id_q[i]] = 1'b1;
      end
    end
  end

  assign req_ready_o   = ready;
  assign outstanding_o = occ;

`ifdef SIMMEM_RELEASE_SCHED_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (rsp_done_i & ~hit) | (req_valid_i & ~ready);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
